// File: rtl/mem_lsu_if.sv
// Valid/ready data bus between the MEM-stage LSU (master) and memory (slave).
// Single outstanding request; request fields hold until the ready handshake.
`ifndef XLEN
`define XLEN 32
`endif

interface mem_lsu_if;
    logic              bus_req_valid_o;
    logic              bus_req_ready_i;
    logic [`XLEN-1:0]  bus_req_addr_o;
    logic              bus_req_we_o;
    logic [`XLEN-1:0]  bus_req_wdata_o;
    logic [3:0]        bus_req_wstrb_o;
    logic              bus_rsp_valid_i;
    logic [`XLEN-1:0]  bus_rsp_rdata_i;
    logic              bus_rsp_err_i;

    modport master (
        output bus_req_valid_o, bus_req_addr_o, bus_req_we_o, bus_req_wdata_o, bus_req_wstrb_o,
        input  bus_req_ready_i, bus_rsp_valid_i, bus_rsp_rdata_i, bus_rsp_err_i
    );
    modport slave (
        input  bus_req_valid_o, bus_req_addr_o, bus_req_we_o, bus_req_wdata_o, bus_req_wstrb_o,
        output bus_req_ready_i, bus_rsp_valid_i, bus_rsp_rdata_i, bus_rsp_err_i
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: IDLE->REQ->RESP->DONE bus FSM, stalls upstream while busy.
// Optional LSU_TIMEOUT_EN macro adds a RESP watchdog that forces a bus fault after TIMEOUT_CYC.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif

module mem_lsu #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [`PC_WIDTH-1:0]      ex_mem_pc_i,
    input  logic [`INSTR_WIDTH-1:0]   ex_mem_instr_i,
    input  logic [`XLEN-1:0]          ex_mem_rs2_rdata_i,
    input  logic [`XLEN-1:0]          ex_mem_alu_res_i,
    input  logic [`REG_IDX_WIDTH-1:0] ex_mem_rd_idx_i,
    input  logic                      ex_mem_rd_en_i,
    input  logic [`XLEN-1:0]          ex_mem_rd_wdata_i,
    input  logic [5:0]                ex_mem_excp_i,
    input  logic                      flush_i,
    mem_lsu_if.master                 bus,
    output logic                      mem_stall_o,
    output logic [`PC_WIDTH-1:0]      mem_pc_o,
    output logic [`INSTR_WIDTH-1:0]   mem_instr_o,
    output logic [`REG_IDX_WIDTH-1:0] mem_rd_idx_o,
    output logic                      mem_rd_en_o,
    output logic [`XLEN-1:0]          mem_rd_wdata_o,
    output logic [5:0]                mem_excp_o,
    output logic                      mem_excp_ld_misalign_o,
    output logic                      mem_excp_st_misalign_o,
    output logic                      mem_excp_ld_fault_o,
    output logic                      mem_excp_st_fault_o
);
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("mem_lsu: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    state_t state;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [1:0] off;
    logic       is_load, is_store, mem_op, misalign, excp_any, legal;

    assign opcode   = ex_mem_instr_i[6:0];
    assign funct3   = ex_mem_instr_i[14:12];
    assign off      = ex_mem_alu_res_i[1:0];
    assign is_load  = (opcode == 7'b0000011) &&
                      (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign is_store = (opcode == 7'b0100011) && (funct3 inside {3'b000, 3'b001, 3'b010});
    assign mem_op   = is_load | is_store;
    assign misalign = ((funct3[1:0] == 2'b01) & off[0]) | ((funct3[1:0] == 2'b10) & (off != 2'b00));
    assign excp_any = |ex_mem_excp_i;
    assign legal    = mem_op & ~misalign & ~excp_any;

    logic [`XLEN-1:0] st_wdata;
    logic [3:0]       st_wstrb;

    always_comb begin
        st_wdata = ex_mem_rs2_rdata_i;
        st_wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{ex_mem_rs2_rdata_i[7:0]}};
                st_wstrb = 4'b0001 << off;
            end
            2'b01: begin
                st_wdata = {2{ex_mem_rs2_rdata_i[15:0]}};
                st_wstrb = 4'b0011 << {off[1], 1'b0};
            end
            default: ;
        endcase
    end

    logic [`XLEN-1:0] rdata_q;
    logic             err_q, killed_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            bus.bus_req_valid_o <= 1'b0;
            bus.bus_req_addr_o  <= '0;
            bus.bus_req_we_o    <= 1'b0;
            bus.bus_req_wdata_o <= '0;
            bus.bus_req_wstrb_o <= '0;
            rdata_q             <= '0;
            err_q               <= 1'b0;
            killed_q            <= 1'b0;
            f3_q                <= '0;
            off_q               <= '0;
`ifdef LSU_TIMEOUT_EN
            to_cnt              <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (legal && !flush_i) begin
                    state               <= REQ;
                    bus.bus_req_valid_o <= 1'b1;
                    bus.bus_req_addr_o  <= {ex_mem_alu_res_i[`XLEN-1:2], 2'b00};
                    bus.bus_req_we_o    <= is_store;
                    bus.bus_req_wdata_o <= st_wdata;
                    bus.bus_req_wstrb_o <= is_store ? st_wstrb : 4'b0000;
                    f3_q                <= funct3;
                    off_q               <= off;
                    err_q               <= 1'b0;
                    killed_q            <= 1'b0;
                end
                REQ: if (bus.bus_req_ready_i) begin
                    // Once accepted the response must still be drained, so a flush only marks it killed.
                    bus.bus_req_valid_o <= 1'b0;
                    killed_q            <= flush_i;
                    state               <= RESP;
                end else if (flush_i) begin
                    bus.bus_req_valid_o <= 1'b0;
                    state               <= IDLE;
                end
                RESP: begin
                    if (flush_i) killed_q <= 1'b1;
                    if (bus.bus_rsp_valid_i) begin
                        rdata_q <= bus.bus_rsp_rdata_i;
                        err_q   <= bus.bus_rsp_err_i;
                        state   <= DONE;
`ifdef LSU_TIMEOUT_EN
                        to_cnt  <= '0;
                    end else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err_q   <= 1'b1;
                        state   <= DONE;
                        to_cnt  <= '0;
                    end else begin
                        to_cnt  <= to_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [`XLEN-1:0] shifted, ld_data;

    always_comb begin
        shifted = rdata_q >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_data = {{(`XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{(`XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  ld_data = {{(`XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  ld_data = {{(`XLEN-16){1'b0}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    assign mem_stall_o  = ((state == IDLE) & legal & ~flush_i) | (state == REQ) | (state == RESP);
    assign mem_pc_o     = ex_mem_pc_i;
    assign mem_instr_o  = ex_mem_instr_i;
    assign mem_rd_idx_o = ex_mem_rd_idx_i;
    assign mem_excp_o   = ex_mem_excp_i;

    always_comb begin
        mem_rd_wdata_o         = ex_mem_rd_wdata_i;
        mem_rd_en_o            = ex_mem_rd_en_i & ~flush_i & ~mem_op & ~excp_any;
        mem_excp_ld_misalign_o = 1'b0;
        mem_excp_st_misalign_o = 1'b0;
        mem_excp_ld_fault_o    = 1'b0;
        mem_excp_st_fault_o    = 1'b0;
        case (state)
            IDLE: begin
                mem_excp_ld_misalign_o = is_load  & misalign & ~excp_any & ~flush_i;
                mem_excp_st_misalign_o = is_store & misalign & ~excp_any & ~flush_i;
            end
            DONE: begin
                mem_rd_en_o         = ex_mem_rd_en_i & ~err_q & ~killed_q & ~flush_i;
                if (!bus.bus_req_we_o) mem_rd_wdata_o = ld_data;
                mem_excp_ld_fault_o = err_q & ~killed_q & ~bus.bus_req_we_o;
                mem_excp_st_fault_o = err_q & ~killed_q &  bus.bus_req_we_o;
            end
            default: mem_rd_en_o = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed plus randomized bench for mem_lsu; expectations come from a byte-lane arithmetic model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] pc, instr, rs2, alu, rd_wdata;
    logic [4:0]  rd_idx;
    logic        rd_en, flush;
    logic [5:0]  excp;

    logic        stall, o_rd_en, ld_mis, st_mis, ld_flt, st_flt;
    logic [31:0] o_pc, o_instr, o_wdata;
    logic [4:0]  o_rd_idx;
    logic [5:0]  o_excp;

    int checks = 0;
    int errors = 0;

    mem_lsu_if bus();

    mem_lsu #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mem_pc_i(pc), .ex_mem_instr_i(instr), .ex_mem_rs2_rdata_i(rs2),
        .ex_mem_alu_res_i(alu), .ex_mem_rd_idx_i(rd_idx), .ex_mem_rd_en_i(rd_en),
        .ex_mem_rd_wdata_i(rd_wdata), .ex_mem_excp_i(excp), .flush_i(flush),
        .bus(bus),
        .mem_stall_o(stall), .mem_pc_o(o_pc), .mem_instr_o(o_instr),
        .mem_rd_idx_o(o_rd_idx), .mem_rd_en_o(o_rd_en), .mem_rd_wdata_o(o_wdata),
        .mem_excp_o(o_excp),
        .mem_excp_ld_misalign_o(ld_mis), .mem_excp_st_misalign_o(st_mis),
        .mem_excp_ld_fault_o(ld_flt), .mem_excp_st_fault_o(st_flt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Reference: pick the addressed bytes out of the word, then sign-extend by wrap-around.
    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] w);
        int unsigned sz = size_of(f3);
        logic [31:0] v = w >> (8 * o);
        if (sz < 4) begin
            v = v & ((32'd1 << (8 * sz)) - 1);
            if (!f3[2] && v[8*sz-1]) v = v - (32'd1 << (8 * sz));
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        int unsigned sz = size_of(f3);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_wstrb(input logic [2:0] f3, input logic [1:0] o);
        int unsigned sz = size_of(f3);
        return (sz == 4) ? 32'hF : ((32'd1 << sz) - 1) << o;
    endfunction

    task automatic drive_nop();
        instr = 32'h0000_0013; rd_en = 1'b1; rd_idx = 5'd7; rd_wdata = $urandom;
        alu = $urandom; rs2 = $urandom; excp = '0; flush = 1'b0;
        bus.bus_req_ready_i = 1'b0; bus.bus_rsp_valid_i = 1'b0; bus.bus_rsp_err_i = 1'b0;
    endtask

    task automatic drive_op(input bit st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
        instr = {17'h0, f3, 5'd3, st ? 7'b0100011 : 7'b0000011};
        rd_en = ~st; rd_idx = 5'd3; rd_wdata = $urandom; alu = addr; rs2 = d; excp = '0; flush = 1'b0;
        pc = $urandom;
    endtask

    task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d,
                       input logic [31:0] rdata, input bit err, input int rdy, input int rsp, input bit kill);
        @(negedge clk);
        drive_op(st, f3, addr, d);
        bus.bus_req_ready_i = 1'b0; bus.bus_rsp_valid_i = 1'b0;
        #1;
        chk("idle_stall", stall, 1);
        chk("idle_req_valid", bus.bus_req_valid_o, 0);
        for (int k = 0; k <= rdy; k++) begin
            @(negedge clk);
            bus.bus_req_ready_i = (k == rdy);
            #1;
            chk("req_valid", bus.bus_req_valid_o, 1);
            chk("req_addr", bus.bus_req_addr_o, addr & 32'hFFFF_FFFC);
            chk("req_we", bus.bus_req_we_o, st);
            if (st) begin
                chk("req_wdata", bus.bus_req_wdata_o, exp_wdata(f3, d));
                chk("req_wstrb", bus.bus_req_wstrb_o, exp_wstrb(f3, addr[1:0]));
            end
            chk("req_stall", stall, 1);
        end
        for (int k = 0; k <= rsp; k++) begin
            @(negedge clk);
            bus.bus_req_ready_i = 1'b0;
            bus.bus_rsp_valid_i = (k == rsp);
            bus.bus_rsp_rdata_i = (k == rsp) ? rdata : $urandom;
            bus.bus_rsp_err_i   = (k == rsp) ? err : 1'b1;
            flush = kill && (k == 0);
            #1;
            chk("resp_stall", stall, 1);
            chk("resp_req_valid", bus.bus_req_valid_o, 0);
            chk("resp_rd_en", o_rd_en, 0);
        end
        @(negedge clk);
        bus.bus_rsp_valid_i = 1'b0; flush = 1'b0;
        #1;
        chk("done_stall", stall, 0);
        chk("done_rd_en", o_rd_en, (!st && !err && !kill));
        if (!st && !err && !kill) chk("done_rd_wdata", o_wdata, exp_load(f3, addr[1:0], rdata));
        chk("done_ld_fault", ld_flt, (!st && err && !kill));
        chk("done_st_fault", st_flt, (st && err && !kill));
        chk("done_pc", o_pc, pc);
        @(negedge clk);
        drive_nop();
        #1;
        chk("after_stall", stall, 0);
        chk("after_rd_en", o_rd_en, 1);
        chk("after_wdata", o_wdata, rd_wdata);
    endtask

    task automatic misaligned(input bit st, input logic [2:0] f3, input logic [31:0] addr);
        @(negedge clk);
        drive_op(st, f3, addr, $urandom);
        #1;
        chk("mis_stall", stall, 0);
        chk("mis_rd_en", o_rd_en, 0);
        chk("mis_ld_flag", ld_mis, !st);
        chk("mis_st_flag", st_mis, st);
        @(negedge clk);
        drive_nop();
        #1;
        chk("mis_no_req", bus.bus_req_valid_o, 0);
    endtask

    initial begin
        pc = 32'h100; drive_nop(); instr = '0; rd_en = 1'b0;
        bus.bus_rsp_rdata_i = '0;
        #1;
        chk("rst_req_valid", bus.bus_req_valid_o, 0);
        chk("rst_req_addr", bus.bus_req_addr_o, 0);
        chk("rst_req_we", bus.bus_req_we_o, 0);
        chk("rst_req_wdata", bus.bus_req_wdata_o, 0);
        chk("rst_req_wstrb", bus.bus_req_wstrb_o, 0);
        chk("rst_stall", stall, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Main directed operations
        txn(0, 3'b010, 32'h1000, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        txn(0, 3'b000, 32'h1003, 0, 32'h80FF_0000, 0, 0, 0, 0);
        txn(0, 3'b100, 32'h1003, 0, 32'h80FF_0000, 0, 1, 0, 0);
        txn(0, 3'b101, 32'h1002, 0, 32'h80FF_0000, 0, 0, 1, 0);
        txn(0, 3'b001, 32'h1000, 0, 32'h1234_8001, 0, 0, 0, 0);
        txn(1, 3'b000, 32'h2001, 32'h0000_00AB, 0, 0, 0, 0, 0);
        txn(1, 3'b001, 32'h2002, 32'h0000_CDEF, 0, 0, 0, 0, 0);
        txn(1, 3'b010, 32'h2004, 32'h1122_3344, 0, 1, 5, 0, 0);
        txn(0, 3'b010, 32'h1008, 0, 32'h1234_5678, 0, 0, 1, 1);

        misaligned(0, 3'b010, 32'h1002);
        misaligned(1, 3'b001, 32'h2001);
        misaligned(0, 3'b101, 32'h3003);

        // Upstream exception blocks the access and passes the flags through
        @(negedge clk);
        drive_op(0, 3'b010, 32'h4000, 0);
        excp = 6'b000100;
        #1;
        chk("excp_stall", stall, 0);
        chk("excp_rd_en", o_rd_en, 0);
        chk("excp_pass", o_excp, 6'b000100);
        @(negedge clk);
        drive_nop();
        #1;
        chk("excp_no_req", bus.bus_req_valid_o, 0);

        // Flush in REQ before any handshake cancels the request
        @(negedge clk);
        drive_op(0, 3'b010, 32'h5000, 0);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl_req_valid", bus.bus_req_valid_o, 1);
        @(negedge clk);
        drive_nop();
        #1;
        chk("fl_drop_valid", bus.bus_req_valid_o, 0);
        chk("fl_drop_stall", stall, 0);

        // Async reset in the middle of a request
        @(negedge clk);
        drive_op(1, 3'b010, 32'h6000, 32'h55);
        @(negedge clk);
        #1;
        chk("rr_req_valid", bus.bus_req_valid_o, 1);
        rst_n = 1'b0;
        drive_nop();
        #1;
        chk("rr_valid_cleared", bus.bus_req_valid_o, 0);
        chk("rr_addr_cleared", bus.bus_req_addr_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef LSU_TIMEOUT_EN
        @(negedge clk);
        drive_op(0, 3'b010, 32'h7000, 0);
        @(negedge clk);
        bus.bus_req_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.bus_req_ready_i = 1'b0;
            #1;
            chk("to_resp_stall", stall, 1);
        end
        @(negedge clk);
        #1;
        chk("to_ld_fault", ld_flt, 1);
        chk("to_rd_en", o_rd_en, 0);
        @(negedge clk);
        drive_nop();
        bus.bus_rsp_valid_i = 1'b1;
        #1;
        chk("to_stray_stall", stall, 0);
        @(negedge clk);
        bus.bus_rsp_valid_i = 1'b0;
        #1;
        chk("to_stray_ignored", bus.bus_req_valid_o, 0);
`endif

        // Randomized aligned traffic
        for (int n = 0; n < 40; n++) begin
            bit          st = $urandom_range(0, 1);
            logic [2:0]  f3;
            logic [31:0] a;
            if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                logic [2:0] lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                f3 = lf[$urandom_range(0, 4)];
            end
            a = $urandom & ~(size_of(f3) - 1);
            txn(st, f3, a, $urandom, $urandom, ($urandom_range(0, 7) == 0),
                $urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs and drives a single-outstanding valid/ready data bus.
- Produces rd write-back info and exception flags for the MEM/WB register.
- Raises mem_stall_o while a bus access is in flight; the EX/MEM register and all upstream stages hold while it is high.
- Non-memory instructions pass through combinationally with zero added latency.

Parameters:
TIMEOUT_CYC, 255, max cycles waiting in RESP before forced bus error (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
ex_mem_pc_i  in  `PC_WIDTH  instr PC
ex_mem_instr_i  in  `INSTR_WIDTH  instr word; opcode [6:0], funct3 [14:12]
ex_mem_rs2_rdata_i  in  `XLEN  store data
ex_mem_alu_res_i  in  `XLEN  effective address / ALU result
ex_mem_rd_idx_i  in  `REG_IDX_WIDTH  dest reg
ex_mem_rd_en_i  in  1  dest write enable
ex_mem_rd_wdata_i  in  `XLEN  non-load write data
ex_mem_excp_i  in  6  {mret,ebreak,ecall,ilegl_instr,if_bus_err,if_misalign}
flush_i  in  1  kill current instruction
bus_req_valid_o  out  1  request valid
bus_req_ready_i  in  1  request accepted
bus_req_addr_o  out  `XLEN  word address, [1:0]=0
bus_req_we_o  out  1  1=store
bus_req_wdata_o  out  `XLEN  lane-replicated store data
bus_req_wstrb_o  out  4  byte strobes
bus_rsp_valid_i  in  1  response valid
bus_rsp_rdata_i  in  `XLEN  read word
bus_rsp_err_i  in  1  access fault
mem_stall_o  out  1  hold upstream
mem_pc_o, mem_instr_o  out  `PC_WIDTH/`INSTR_WIDTH  pass-through
mem_rd_idx_o  out  `REG_IDX_WIDTH  dest reg
mem_rd_en_o  out  1  dest write enable
mem_rd_wdata_o  out  `XLEN  write-back data
mem_excp_o  out  6  upstream exceptions, passed through
mem_excp_ld_misalign_o, mem_excp_st_misalign_o, mem_excp_ld_fault_o, mem_excp_st_fault_o  out  1 each

Behaviour:
- Decode: load = opcode 0000011 (funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU); store = opcode 0100011 (000 SB, 001 SH, 010 SW). Any other funct3 is treated as non-memory.
- Reset: state IDLE; all bus_req_* = 0; result regs 0; timeout counter 0; mem_stall_o = 0.
- Misalignment: H with addr[0]=1, or W with addr[1:0]!=0.
  - Raises ld/st_misalign for that cycle; no bus access; rd_en_o=0; stall=0.
- Any ex_mem_excp_i bit set: no bus access; rd_en_o=0; flags passed through.
- FSM IDLE -> REQ -> RESP -> DONE -> IDLE:
  - IDLE: legal mem op and no flush -> stall=1, register addr/we/wdata/wstrb, go to REQ.
  - REQ: bus_req_valid_o=1; request fields stable until bus_req_ready_i. On handshake go to RESP (req_valid drops next cycle).
  - RESP: on bus_rsp_valid_i, capture data/err, go to DONE. Responses outside RESP are ignored.
  - DONE: stall=0; outputs present the result for exactly one cycle, then IDLE.
- mem_stall_o = (IDLE & legal mem op) | REQ | RESP.
- Minimum load/store latency: 4 cycles with ready and rsp arriving in the first possible cycles.
- Store lanes: SB wdata = {4{rs2[7:0]}}, wstrb = 0001<<addr[1:0]. SH wdata = {2{rs2[15:0]}}, wstrb = 0011<<(2*addr[1]). SW wstrb = 1111.
- Load extraction: byte/half selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. Result drives mem_rd_wdata_o in DONE.
- Bus error in DONE: ld_fault or st_fault = 1, rd_en_o=0.
- Store in DONE: rd_en_o = ex_mem_rd_en_i (always 0 for a legal store).
- flush_i:
  - In IDLE: suppresses the access.
  - In REQ before handshake: return to IDLE, no request issued further.
  - In REQ with a same-cycle handshake, or in RESP: mark killed, still wait for the response, then DONE with rd_en_o=0 and no fault flags.
- Async reset mid-transaction drops to IDLE immediately; the bus side is reset by the same rst_n.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined: counter increments each RESP cycle; reaching TIMEOUT_CYC with no rsp forces DONE with err=1 (fault flag). A later stray response is ignored.
- Undefined: no counter; RESP waits indefinitely.

Test Plan:
- LW addr 0x1000, ready and rsp immediate, rdata 0xDEADBEEF -> req addr 0x1000, stall high 3 cycles, DONE rd_wdata 0xDEADBEEF, rd_en 1.
- LB addr 0x1003, rdata 0x80FF_0000 -> 0xFFFFFF80; LBU -> 0x00000080; LHU addr 0x1002 -> 0x000080FF.
- SB addr 0x2001, rs2 0x000000AB -> wdata 0xABABABAB, wstrb 0010, we 1; SH addr 0x2002 -> wstrb 1100.
- LW addr 0x1002 -> ld_misalign 1, no bus_req_valid, stall 0, rd_en 0; SH addr 0x2001 -> st_misalign 1.
- bus_req_ready low 5 cycles, then rsp_err=1 on a store -> request fields stable across the wait, st_fault 1 in DONE.
- flush_i in RESP, rsp 0x12345678 -> DONE rd_en 0, no flags. With LSU_TIMEOUT_EN and TIMEOUT_CYC=4, no response -> ld_fault after 4 RESP cycles.
